// File: rtl/sprite_pkg.sv
// Shared types for the sprite palette encoder.
// RGB444 pixel struct, palette size, encoder FSM states.
package sprite_pkg;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam int PAL_ENTRIES = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } enc_state_t;
endpackage

// File: rtl/sprite_palette_encoder_if.sv
// Palette write port plus pixel-in / index-out handshakes.
// master drives pixels and palette, slave is the encoder.
interface sprite_palette_encoder_if;
  import sprite_pkg::*;

  logic       pal_we;
  logic [3:0] pal_waddr;
  rgb444_t    pal_wdata;
  logic       in_valid;
  logic       in_ready;
  rgb444_t    in_rgb;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_index;
  logic       out_exact;

  modport master (
    output pal_we, pal_waddr, pal_wdata,
    output in_valid, in_rgb, out_ready,
    input  in_ready, out_valid,
    input  out_index, out_exact
  );

  modport slave (
    input  pal_we, pal_waddr, pal_wdata,
    input  in_valid, in_rgb, out_ready,
    output in_ready, out_valid,
    output out_index, out_exact
  );
endinterface

// File: rtl/rgb_l1_distance.sv
// L1 distance between two RGB444 colours, 0..45.
// Pure combinational.
module rgb_l1_distance
  import sprite_pkg::*;
(
  input  rgb444_t    i_a,
  input  rgb444_t    i_b,
  output logic [5:0] o_dist
);
  logic [3:0] w_dr;
  logic [3:0] w_dg;
  logic [3:0] w_db;

  assign w_dr = (i_a.r > i_b.r) ? i_a.r - i_b.r : i_b.r - i_a.r;
  assign w_dg = (i_a.g > i_b.g) ? i_a.g - i_b.g : i_b.g - i_a.g;
  assign w_db = (i_a.b > i_b.b) ? i_a.b - i_b.b : i_b.b - i_a.b;

  assign o_dist = {2'b00, w_dr} + {2'b00, w_dg} + {2'b00, w_db};
endmodule

// File: rtl/sprite_palette_encoder.sv
// Nearest-palette-entry encoder for RGB444 pixels.
// Walks one palette entry per clock; exact hits exit early.
module sprite_palette_encoder
  import sprite_pkg::*;
#(
  parameter int unsigned KEY_IDX     = 1,
  parameter bit          EXCLUDE_KEY = 1'b1
) (
  input logic                      Clk,
  input logic                      Reset_n,
  sprite_palette_encoder_if.slave  bus
);
  rgb444_t    r_pal [PAL_ENTRIES];
  enc_state_t r_state;
  enc_state_t w_next;
  rgb444_t    r_px;
  logic [3:0] r_idx;
  logic [5:0] r_best_dist;
  logic [3:0] r_best_idx;

  logic [5:0] w_dist;
  logic       w_skip;
  logic       w_hit;
  logic       w_upd;
  logic       w_last;
  logic       w_accept;

  rgb_l1_distance u_dist (
    .i_a    (r_px),
    .i_b    (r_pal[r_idx]),
    .o_dist (w_dist)
  );

  assign w_skip   = EXCLUDE_KEY && (r_idx == 4'(KEY_IDX));
  assign w_hit    = !w_skip && (w_dist == 6'd0);
  assign w_upd    = !w_skip && (w_dist < r_best_dist);
  assign w_last   = (r_idx == 4'd15);
  assign w_accept = (r_state == IDLE) && bus.in_valid;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid) w_next = SEARCH;
      SEARCH:  if (w_hit || w_last) w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Palette writes land in any state; the search reads them live.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        r_pal[i] <= '0;
      end
    end else if (bus.pal_we) begin
      r_pal[bus.pal_waddr] <= bus.pal_wdata;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_px        <= '0;
      r_idx       <= '0;
      r_best_dist <= 6'h3F;
      r_best_idx  <= '0;
    end else if (w_accept) begin
      r_px        <= bus.in_rgb;
      r_idx       <= '0;
      r_best_dist <= 6'h3F;
      r_best_idx  <= '0;
    end else if (r_state == SEARCH) begin
      if (w_upd) begin
        r_best_dist <= w_dist;
        r_best_idx  <= r_idx;
      end
      if (!w_hit && !w_last) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_index = r_best_idx;
  assign bus.out_exact = (r_state == DONE) && (r_best_dist == 6'd0);
endmodule
